gpio_mmio_multi: RTL and testbench
==================================

Name: gpio_mmio_multi

Overview:
Parametrised memory-mapped GPIO output bank and successor to the single-address GPIO.
- N_CH independent output channels, each at its own address.
- A channel latches its output only after the bus has entered that channel's address HITS separate times.
- Adds a per-channel update strobe, registered readback and a control register to abort or clear.
- Sits on the core's data-memory bus and observes address/data/write-enable alongside memory.

Parameters:
DATA_W, 32, width of datos, each channel output and lectura
ADDR_W, 32, width of direccion
N_CH, 4, number of output channels (1..16)
BASE_ADDR, 32'h0000ABCD, address of channel 0
STRIDE, 4, address increment between channels
HITS, 2, address entries required per commit (1..15); 1 = commit on every entry

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
direccion  in  ADDR_W  bus address
datos  in  DATA_W  bus write data
we  in  1  bus write enable
salida  out  N_CH*DATA_W  channel outputs; channel i at bits [i*DATA_W +: DATA_W]
actualizado  out  N_CH  one-cycle pulse, bit i set the cycle after channel i commits
lectura  out  DATA_W  registered readback of the addressed channel
ocupado  out  N_CH  bit i = channel i counter nonzero (commit pending)

Behaviour:
- Reset: one clock; synchronous, active-high. On rst=1 at a clk edge, all state clears: salida=0, actualizado=0, lectura=0, ocupado=0, all counters=0, all prev-hit flags=0. Reset overrides every simultaneous event.
- Channel match: sel_i = we & (direccion == BASE_ADDR + i*STRIDE), compared at ADDR_W bits.
- Control match: ctl = we & (direccion == BASE_ADDR + N_CH*STRIDE).
- Per-channel register prev_i <= sel_i.
- Entry event: ent_i = sel_i & ~prev_i. An address held with we=1 for many cycles counts once. Dropping we or changing address and then returning is a new entry.
- Per-channel counter cnt_i, width ceil(log2(HITS))+1, range 0..HITS-1.
- On ent_i with cnt_i < HITS-1: cnt_i <= cnt_i+1, salida unchanged.
- On ent_i with cnt_i == HITS-1: salida_i <= datos sampled in that same cycle, cnt_i <= 0, actualizado[i] <= 1 for exactly one cycle.
- actualizado[i] is 0 in all other cycles.
- Data on earlier entries is ignored; only data on the committing entry is stored.
- Channels are independent. Entries to channel j never alter cnt_i for i != j.
- ocupado[i] = (cnt_i != 0), combinational from the counter.
- Control register writes (one-cycle effect on any ctl cycle, not entry-gated):
  - datos[0]=1: all cnt_i <= 0 (abort pending commits).
  - datos[1]=1: all salida_i <= 0.
  - Both bits may be set together.
- Control/commit in the same cycle is impossible because addresses differ. A ctl write takes effect while prev flags keep updating normally.
- Readback: lectura <= salida_k when direccion == BASE_ADDR + k*STRIDE (any we), else 0. One-cycle latency.
- Readback reflects salida before any commit in that same cycle.
- Address compare has no wrap: addresses beyond the control register match nothing.

Test Plan:
1. rst=1 for 2 cycles with datos=4, direccion=ABCD, we=1 → salida=0, actualizado=0, lectura=0, cnt=0; after release the held address counts as one entry (cnt_0=1, ocupado[0]=1).
2. Defaults: we=1, direccion ABCD (datos=4) 4 cycles, then 0 for 4, then ABCD (datos=9) → channel 0 = 9 one cycle after the second entry; actualizado[0] pulses one cycle; ocupado[0] returns 0.
3. Hold ABCD with we=1 for 10 cycles → a single entry only; salida unchanged, ocupado[0]=1.
4. Interleave entries ABCD, ABD1, ABCD(datos=5), ABD1(datos=7) → channel0=5, channel1=7, each strobed on its own second entry; channels 2/3 stay 0.
5. One entry to ABD5, then a ctl write to ABDD with datos=1, then one more entry → no commit (cnt_2=1); with datos=3 all outputs also clear to 0.
6. HITS=1 build: entry with datos=32'hDEADBEEF → commit next cycle. Then we=0, direccion=ABCD → lectura=DEADBEEF one cycle later; direccion=0 → lectura=0.

Source files
------------

// File: rtl/gpio_mmio_multi.sv
// Memory-mapped GPIO output bank: N_CH channels, each committing bus data to its
// output only on the HITS-th separate entry to its address, with strobe, readback and control.
module gpio_mmio_multi #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                N_CH      = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000ABCD,
    parameter int                STRIDE    = 4,
    parameter int                HITS      = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        direccion,
    input  logic [DATA_W-1:0]        datos,
    input  logic                     we,
    output logic [N_CH*DATA_W-1:0]   salida,
    output logic [N_CH-1:0]          actualizado,
    output logic [DATA_W-1:0]        lectura,
    output logic [N_CH-1:0]          ocupado
);

    localparam int            CW   = $clog2(HITS) + 1;
    localparam logic [CW-1:0] LAST = CW'(HITS - 1);

    function automatic logic [ADDR_W-1:0] slot_addr(input int idx);
        return BASE_ADDR + ADDR_W'(idx * STRIDE);
    endfunction

    logic [DATA_W-1:0] salida_q [N_CH];
    logic [DATA_W-1:0] salida_d [N_CH];
    logic [CW-1:0]     cnt_q    [N_CH];
    logic [CW-1:0]     cnt_d    [N_CH];
    logic [N_CH-1:0]   prev_q, prev_d;
    logic [N_CH-1:0]   act_q, act_d;
    logic [DATA_W-1:0] lectura_q, lectura_d;

    logic [N_CH-1:0]   sel;
    logic [N_CH-1:0]   ent;
    logic              ctl;

    always_comb begin
        sel = '0;
        for (int i = 0; i < N_CH; i++) begin
            sel[i] = we && (direccion == slot_addr(i));
        end
        ent = sel & ~prev_q;
        ctl = we && (direccion == slot_addr(N_CH));
    end

    always_comb begin
        prev_d    = sel;
        act_d     = '0;
        lectura_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            salida_d[i] = salida_q[i];
            cnt_d[i]    = cnt_q[i];
            // Readback samples the pre-commit value of the addressed channel.
            if (direccion == slot_addr(i)) begin
                lectura_d = salida_q[i];
            end
            if (ent[i]) begin
                if (cnt_q[i] == LAST) begin
                    salida_d[i] = datos;
                    cnt_d[i]    = '0;
                    act_d[i]    = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
        // Control and channel addresses never coincide, so no commit competes with this.
        if (ctl) begin
            for (int i = 0; i < N_CH; i++) begin
                if (datos[0]) begin
                    cnt_d[i] = '0;
                end
                if (datos[1]) begin
                    salida_d[i] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q    <= '0;
            act_q     <= '0;
            lectura_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                salida_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            prev_q    <= prev_d;
            act_q     <= act_d;
            lectura_q <= lectura_d;
            for (int i = 0; i < N_CH; i++) begin
                salida_q[i] <= salida_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
        end
    end

    always_comb begin
        salida  = '0;
        ocupado = '0;
        for (int i = 0; i < N_CH; i++) begin
            salida[i*DATA_W +: DATA_W] = salida_q[i];
            ocupado[i]                 = (cnt_q[i] != '0);
        end
    end

    assign actualizado = act_q;
    assign lectura     = lectura_q;

endmodule

// File: tb/tb_gpio_mmio_multi.sv
// Scoreboard bench for gpio_mmio_multi: a default (HITS=2) instance and a HITS=1 instance.
module tb_gpio_mmio_multi;

    localparam int N_CH = 4;
    localparam int DW   = 32;

    typedef struct {
        int          ch;
        logic [31:0] data;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int errors = 0;
    int checks = 0;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [31:0]        dir = '0, dat = '0;
    logic               we  = 1'b0;
    logic [31:0]        dir1 = '0, dat1 = '0;
    logic               we1  = 1'b0;

    logic [N_CH*DW-1:0] sal, sal1;
    logic [N_CH-1:0]    act, act1, ocu, ocu1;
    logic [DW-1:0]      lec, lec1;

    always #5 clk = ~clk;

    gpio_mmio_multi dut (
        .clk(clk), .rst(rst), .direccion(dir), .datos(dat), .we(we),
        .salida(sal), .actualizado(act), .lectura(lec), .ocupado(ocu)
    );

    gpio_mmio_multi #(.HITS(1)) dut1 (
        .clk(clk), .rst(rst), .direccion(dir1), .datos(dat1), .we(we1),
        .salida(sal1), .actualizado(act1), .lectura(lec1), .ocupado(ocu1)
    );

    // Commit monitors: every strobe bit consumes one expected commit.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_CH; i++) begin
                if (act[i]) begin
                    exp_t e;
                    checks++;
                    if (q0.size() == 0) begin
                        errors++;
                        $display("FAIL commit0 unexpected strobe ch%0d got data=%h required no commit", i, sal[i*DW +: DW]);
                    end else begin
                        e = q0.pop_front();
                        if (e.ch != i || sal[i*DW +: DW] != e.data) begin
                            errors++;
                            $display("FAIL commit0 got ch%0d data=%h required ch%0d data=%h", i, sal[i*DW +: DW], e.ch, e.data);
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_CH; i++) begin
                if (act1[i]) begin
                    exp_t e;
                    checks++;
                    if (q1.size() == 0) begin
                        errors++;
                        $display("FAIL commit1 unexpected strobe ch%0d got data=%h required no commit", i, sal1[i*DW +: DW]);
                    end else begin
                        e = q1.pop_front();
                        if (e.ch != i || sal1[i*DW +: DW] != e.data) begin
                            errors++;
                            $display("FAIL commit1 got ch%0d data=%h required ch%0d data=%h", i, sal1[i*DW +: DW], e.ch, e.data);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic w);
        dir = a; dat = d; we = w;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cyc1(input logic [31:0] a, input logic [31:0] d, input logic w);
        dir1 = a; dat1 = d; we1 = w;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push0(input int ch, input logic [31:0] d);
        exp_t e;
        e.ch = ch; e.data = d;
        q0.push_back(e);
    endtask

    task automatic push1(input int ch, input logic [31:0] d);
        exp_t e;
        e.ch = ch; e.data = d;
        q1.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held two cycles with an active write on channel 0
        rst = 1'b1;
        cyc(32'hABCD, 32'd4, 1'b1);
        cyc(32'hABCD, 32'd4, 1'b1);
        chk("rst_salida", sal, 128'd0);
        chk("rst_actualizado", act, 128'd0);
        chk("rst_lectura", lec, 128'd0);
        chk("rst_ocupado", ocu, 128'd0);
        chk("rst_lectura1", lec1, 128'd0);
        rst = 1'b0;
        cyc(32'hABCD, 32'd4, 1'b1);
        chk("post_rst_entry_ocupado", ocu, 128'h1);

        // Held address counts once; leave and return commits data 9
        repeat (3) cyc(32'hABCD, 32'd4, 1'b1);
        chk("hold4_ocupado", ocu, 128'h1);
        chk("hold4_salida", sal, 128'd0);
        repeat (4) cyc(32'h0, 32'd0, 1'b1);
        push0(0, 32'd9);
        cyc(32'hABCD, 32'd9, 1'b1);
        chk("commit_ocupado_clear", ocu, 128'h0);
        chk("readback_precommit", lec, 128'd0);
        cyc(32'hABCD, 32'd9, 1'b1);
        chk("readback_after_commit", lec, 128'd9);
        chk("salida_ch0_9", sal, 128'd9);

        // Long hold is a single entry
        cyc(32'h0, 32'd0, 1'b0);
        repeat (10) cyc(32'hABCD, 32'h11, 1'b1);
        chk("long_hold_ocupado", ocu, 128'h1);
        chk("long_hold_salida", sal, 128'd9);

        // Abort via control
        cyc(32'hABDD, 32'd1, 1'b1);
        chk("abort_ocupado", ocu, 128'h0);
        chk("abort_salida_kept", sal, 128'd9);

        // Interleaved channels 0 and 1
        cyc(32'hABCD, 32'hAA, 1'b1);
        cyc(32'hABD1, 32'hBB, 1'b1);
        chk("interleave_ocupado", ocu, 128'h3);
        push0(0, 32'd5);
        cyc(32'hABCD, 32'd5, 1'b1);
        chk("interleave_ocupado_ch1", ocu, 128'h2);
        push0(1, 32'd7);
        cyc(32'hABD1, 32'd7, 1'b1);
        chk("interleave_ocupado_done", ocu, 128'h0);
        chk("interleave_salida", sal, {32'd0, 32'd0, 32'd7, 32'd5});

        // Readback with we=0, and an address beyond the control register
        cyc(32'hABD1, 32'd0, 1'b0);
        chk("readback_ch1", lec, 128'd7);
        chk("read_no_entry", ocu, 128'h0);
        cyc(32'hABE1, 32'hFF, 1'b1);
        chk("beyond_ctl_lectura", lec, 128'd0);
        chk("beyond_ctl_ocupado", ocu, 128'h0);

        // Abort on channel 2, then clear-all
        cyc(32'hABD5, 32'd1, 1'b1);
        chk("ch2_pending", ocu, 128'h4);
        cyc(32'hABDD, 32'd1, 1'b1);
        chk("ch2_aborted", ocu, 128'h0);
        cyc(32'hABD5, 32'h77, 1'b1);
        chk("ch2_no_commit", ocu, 128'h4);
        chk("ch2_salida_kept", sal, {32'd0, 32'd0, 32'd7, 32'd5});
        cyc(32'hABDD, 32'd3, 1'b1);
        chk("clear_all_ocupado", ocu, 128'h0);
        chk("clear_all_salida", sal, 128'd0);

        // Clear outputs only: pending count survives
        cyc(32'hABD5, 32'd1, 1'b1);
        cyc(32'hABDD, 32'd2, 1'b1);
        chk("clear_out_keeps_cnt", ocu, 128'h4);
        push0(2, 32'h55);
        cyc(32'hABD5, 32'h55, 1'b1);
        chk("ch2_commit_salida", sal, {32'd0, 32'h55, 32'd0, 32'd0});
        cyc(32'h0, 32'd0, 1'b0);

        // HITS=1 instance
        push1(0, 32'hDEADBEEF);
        cyc1(32'hABCD, 32'hDEADBEEF, 1'b1);
        chk("h1_ocupado", ocu1, 128'h0);
        cyc1(32'hABCD, 32'd0, 1'b0);
        chk("h1_readback", lec1, 128'hDEADBEEF);
        cyc1(32'h0, 32'd0, 1'b0);
        chk("h1_readback_none", lec1, 128'd0);
        push1(1, 32'h12345678);
        cyc1(32'hABD1, 32'h12345678, 1'b1);
        cyc1(32'h0, 32'd0, 1'b0);
        chk("h1_salida", sal1, {32'd0, 32'd0, 32'h12345678, 32'hDEADBEEF});

        repeat (2) cyc(32'h0, 32'd0, 1'b0);
        chk("q0_drained", 128'(q0.size()), 128'd0);
        chk("q1_drained", 128'(q1.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
